rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl_if.sv | 41 ++++
 rtl/rx_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_ctrl_if.sv
// rx_frame_ctrl_if: sample and status bus of the RX frame controller.
//   slave  modport : the controller (consumes sync/din, drives dout/status)
//   master modport : upstream/environment side
//   sync_det              frame-sync pulse from timing sync
//   din_re/din_im/din_vld input samples (12-bit signed) and valid
//   dout_re/dout_im/dout_vld/dout_is_signal/sym_idx  forwarded samples
//   frame_start/frame_done/frame_abort/err_overrun   status pulses
//   ds_rst/busy           downstream soft reset, controller busy
interface rx_frame_ctrl_if;
    localparam int unsigned DW = 12;

    logic                 sync_det;
    logic signed [DW-1:0] din_re;
    logic signed [DW-1:0] din_im;
    logic                 din_vld;

    logic signed [DW-1:0] dout_re;
    logic signed [DW-1:0] dout_im;
    logic                 dout_vld;
    logic                 dout_is_signal;
    logic [2:0]           sym_idx;

    logic                 frame_start;
    logic                 frame_done;
    logic                 frame_abort;
    logic                 err_overrun;
    logic                 ds_rst;
    logic                 busy;

    modport slave (
        input  sync_det, din_re, din_im, din_vld,
        output dout_re, dout_im, dout_vld, dout_is_signal, sym_idx,
        output frame_start, frame_done, frame_abort, err_overrun, ds_rst, busy
    );

    modport master (
        output sync_det, din_re, din_im, din_vld,
        input  dout_re, dout_im, dout_vld, dout_is_signal, sym_idx,
        input  frame_start, frame_done, frame_abort, err_overrun, ds_rst, busy
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: frames an OFDM receive stream after timing sync.
// Forwards one signal symbol plus NSYM-1 payload symbols of N samples each
// with a fixed one-cycle latency, guards against input starvation, then
// drains, soft-resets the downstream blocks and waits a guard gap.
//   clk  single working clock
//   rst  synchronous active-high reset
//   bus  rx_frame_ctrl_if.slave (samples in/out, status pulses, ds_rst, busy)
module rx_frame_ctrl #(
    parameter int unsigned N         = 64,
    parameter int unsigned NSYM      = 7,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic               clk,
    input  logic               rst,
    rx_frame_ctrl_if.slave     bus
);
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW   = $clog2(TIMEOUT + 1);
    localparam int unsigned PMAX = (FLUSH_CYC > GAP_CYC) ? FLUSH_CYC : GAP_CYC;
    localparam int unsigned PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIG   = 3'd1,
        PLD   = 3'd2,
        DRAIN = 3'd3,
        CLR   = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] samp_cnt;
    logic [2:0]    sym_cnt;
    logic [IW-1:0] idle_cnt;
    logic [PW-1:0] phase_cnt;

    // Single-process FSM; every output is a register updated with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            samp_cnt           <= '0;
            sym_cnt            <= '0;
            idle_cnt           <= '0;
            phase_cnt          <= '0;
            bus.dout_re        <= '0;
            bus.dout_im        <= '0;
            bus.dout_vld       <= 1'b0;
            bus.dout_is_signal <= 1'b0;
            bus.sym_idx        <= '0;
            bus.frame_start    <= 1'b0;
            bus.frame_done     <= 1'b0;
            bus.frame_abort    <= 1'b0;
            bus.err_overrun    <= 1'b0;
            bus.ds_rst         <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            // Data outputs are zero whenever no sample is presented.
            bus.dout_re        <= '0;
            bus.dout_im        <= '0;
            bus.dout_vld       <= 1'b0;
            bus.dout_is_signal <= 1'b0;
            bus.sym_idx        <= '0;
            bus.frame_start    <= 1'b0;
            bus.frame_done     <= 1'b0;
            bus.frame_abort    <= 1'b0;
            bus.err_overrun    <= 1'b0;
            bus.ds_rst         <= 1'b0;
            bus.busy           <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.sync_det) begin
                        state           <= SIG;
                        bus.frame_start <= 1'b1;
                        samp_cnt        <= '0;
                        sym_cnt         <= '0;
                        idle_cnt        <= '0;
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end

                SIG, PLD: begin
                    // A second sync inside a frame is flagged but not acted on.
                    bus.err_overrun <= bus.sync_det;
                    if (bus.din_vld) begin
                        bus.dout_re        <= bus.din_re;
                        bus.dout_im        <= bus.din_im;
                        bus.dout_vld       <= 1'b1;
                        bus.dout_is_signal <= (state == SIG);
                        bus.sym_idx        <= sym_cnt;
                        idle_cnt           <= '0;
                        if (samp_cnt == CW'(N - 1)) begin
                            samp_cnt <= '0;
                            sym_cnt  <= sym_cnt + 3'd1;
                            if (state == SIG) begin
                                state <= PLD;
                            end else if (sym_cnt == 3'(NSYM - 1)) begin
                                state          <= DRAIN;
                                phase_cnt      <= '0;
                                bus.frame_done <= 1'b1;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + CW'(1);
                        end
                    end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                        // TIMEOUT-th consecutive empty cycle: give up on the frame.
                        state           <= DRAIN;
                        phase_cnt       <= '0;
                        idle_cnt        <= '0;
                        bus.frame_abort <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end

                DRAIN: begin
                    if (phase_cnt == PW'(FLUSH_CYC - 1)) begin
                        state      <= CLR;
                        phase_cnt  <= '0;
                        bus.ds_rst <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end

                CLR: begin
                    state     <= GAP;
                    phase_cnt <= '0;
                end

                GAP: begin
                    if (phase_cnt == PW'(GAP_CYC - 1)) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                        bus.busy  <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: randomized self-checking bench for rx_frame_ctrl.
// The reference model tracks a frame as "accepted sample count + idle run"
// and derives drain/clear/gap timing arithmetically from the cycle the frame
// ended.
module tb_rx_frame_ctrl;
    localparam int N         = 64;
    localparam int NSYM      = 7;
    localparam int TIMEOUT   = 16;
    localparam int FLUSH_CYC = 2;
    localparam int GAP_CYC   = 4;

    logic clk;
    logic rst;
    rx_frame_ctrl_if bus();

    rx_frame_ctrl #(
        .N(N), .NSYM(NSYM), .TIMEOUT(TIMEOUT),
        .FLUSH_CYC(FLUSH_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    // Reference model state.
    bit m_in    = 1'b0;
    int m_acc   = 0;
    int m_idle  = 0;
    int m_end   = -1000;

    // Observed event counters per scenario.
    int n_vld, n_done, n_abort, n_ovr, n_start;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic clr_counts();
        n_vld = 0; n_done = 0; n_abort = 0; n_ovr = 0; n_start = 0;
    endtask

    // One clock cycle: drive inputs, predict outputs, check after the edge.
    task automatic cyc(input logic s, input logic v, input logic r);
        logic signed [11:0] re, im;
        logic signed [11:0] e_re, e_im;
        logic       e_vld, e_sig;
        logic [2:0] e_sym;
        logic [5:0] e_stat;
        logic       e_start, e_done, e_abort, e_ovr, e_dsr, e_busy;
        re = 12'($urandom);
        im = 12'($urandom);
        rst          = r;
        bus.sync_det = s;
        bus.din_vld  = v;
        bus.din_re   = re;
        bus.din_im   = im;

        e_re = '0; e_im = '0; e_vld = 1'b0; e_sig = 1'b0; e_sym = '0;
        e_start = 1'b0; e_done = 1'b0; e_abort = 1'b0; e_ovr = 1'b0;
        e_dsr = 1'b0; e_busy = 1'b0;

        if (r) begin
            m_in  = 1'b0;
            m_end = -1000;
        end else if (m_in) begin
            e_busy = 1'b1;
            e_ovr  = s;
            if (v) begin
                e_vld = 1'b1;
                e_re  = re;
                e_im  = im;
                e_sig = (m_acc < N);
                e_sym = 3'(m_acc / N);
                m_acc++;
                m_idle = 0;
                if (m_acc == N * NSYM) begin
                    e_done = 1'b1;
                    m_in   = 1'b0;
                    m_end  = t + 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    e_abort = 1'b1;
                    m_in    = 1'b0;
                    m_end   = t + 1;
                end
            end
        end else if (t < m_end + FLUSH_CYC + 1 + GAP_CYC) begin
            e_busy = (t + 1 < m_end + FLUSH_CYC + 1 + GAP_CYC);
            e_dsr  = (t + 1 == m_end + FLUSH_CYC);
        end else if (s) begin
            e_start = 1'b1;
            e_busy  = 1'b1;
            m_in    = 1'b1;
            m_acc   = 0;
            m_idle  = 0;
        end
        e_stat = {e_start, e_done, e_abort, e_ovr, e_dsr, e_busy};

        @(posedge clk);
        #1;
        t++;
        chk("dout_vld", 32'(bus.dout_vld), 32'(e_vld));
        chk("dout_re", 32'(bus.dout_re), 32'(e_re));
        chk("dout_im", 32'(bus.dout_im), 32'(e_im));
        chk("dout_is_signal", 32'(bus.dout_is_signal), 32'(e_sig));
        chk("sym_idx", 32'(bus.sym_idx), 32'(e_sym));
        chk("status", 32'({bus.frame_start, bus.frame_done, bus.frame_abort,
                           bus.err_overrun, bus.ds_rst, bus.busy}), 32'(e_stat));
        n_vld   += int'(bus.dout_vld);
        n_done  += int'(bus.frame_done);
        n_abort += int'(bus.frame_abort);
        n_ovr   += int'(bus.err_overrun);
        n_start += int'(bus.frame_start);
    endtask

    task automatic samples(input int cnt);
        for (int i = 0; i < cnt; i++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic idles(input int cnt);
        for (int i = 0; i < cnt; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.sync_det = 1'b0;
        bus.din_vld  = 1'b0;
        bus.din_re   = '0;
        bus.din_im   = '0;

        // Reset, then valid samples in IDLE that must be dropped.
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        clr_counts();
        repeat (6) cyc(1'b0, 1'b1, 1'b0);
        chk("idle_drop_vld", 32'(n_vld), 32'd0);

        // Full frame with an in-frame sync (overrun) partway through payload.
        clr_counts();
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < N * NSYM; i++) cyc(1'b0 || (i == 300), 1'b1, 1'b0);
        idles(10);
        chk("full_vld", 32'(n_vld), 32'(N * NSYM));
        chk("full_done", 32'(n_done), 32'd1);
        chk("full_abort", 32'(n_abort), 32'd0);
        chk("full_ovr", 32'(n_ovr), 32'd1);

        // Tolerated 10-cycle gap after sample 200.
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0);
        samples(200);
        idles(10);
        samples(N * NSYM - 200);
        idles(10);
        chk("gap_vld", 32'(n_vld), 32'(N * NSYM));
        chk("gap_done", 32'(n_done), 32'd1);
        chk("gap_abort", 32'(n_abort), 32'd0);

        // Starvation timeout after 100 samples.
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0);
        samples(100);
        idles(TIMEOUT + 10);
        chk("to_vld", 32'(n_vld), 32'd100);
        chk("to_done", 32'(n_done), 32'd0);
        chk("to_abort", 32'(n_abort), 32'd1);

        // Sync held through drain/clear/gap starts the next frame at first IDLE.
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0);
        samples(N * NSYM);
        repeat (FLUSH_CYC + 1 + GAP_CYC + 1) cyc(1'b1, 1'b1, 1'b0);
        samples(N * NSYM);
        idles(10);
        chk("b2b_start", 32'(n_start), 32'd2);
        chk("b2b_done", 32'(n_done), 32'd2);
        chk("b2b_ovr", 32'(n_ovr), 32'd0);

        // Reset mid-payload, then a clean frame.
        clr_counts();
        cyc(1'b1, 1'b0, 1'b0);
        samples(300);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        samples(N * NSYM);
        idles(10);
        chk("rst_vld", 32'(n_vld), 32'(300 + N * NSYM));
        chk("rst_done", 32'(n_done), 32'd1);
        chk("rst_abort", 32'(n_abort), 32'd0);

        // Random traffic with pauses, stray syncs and occasional resets.
        begin
            int pause = 0;
            for (int i = 0; i < 6000; i++) begin
                logic s, v, r;
                if (pause == 0 && $urandom_range(99) == 0) pause = $urandom_range(25, 3);
                v = (pause == 0) && ($urandom_range(9) != 0);
                if (pause > 0) pause--;
                s = ($urandom_range(59) == 0);
                r = ($urandom_range(2999) == 0);
                cyc(s, v, r);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
